dm_resp: RTL and testbench

Data-memory responder for the MEM pipeline stage. Accepts the stage's read and write strobes, models a multi-cycle memory with a configurable access latency, and holds the pipeline via `stall` until the access completes. For reads it returns `rd_data` with a one-cycle `rd_valid` pulse. It sits directly below MEM on the same addr/re/we/wrt_data/rd_data interface.

---
 rtl/dm_resp_pkg.sv | 26 ++
 rtl/dm_resp_if.sv | 25 ++
 rtl/dm_array.sv | 29 ++
 rtl/dm_resp.sv | 164 ++++++++++++++++
 tb/tb_dm_resp.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dm_resp_pkg.sv
// Shared types and encodings for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_resp_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      DM_IDLE = 2'b00,
      DM_BUSY = 2'b01,
      DM_DONE = 2'b10
   } dm_state_e;

   typedef enum logic {
      DM_OP_RD = 1'b0,
      DM_OP_WR = 1'b1
   } dm_op_e;

   // Write wins when both strobes are raised together.
   function automatic dm_op_e dm_decode_op(input logic we);
      return we ? DM_OP_WR : DM_OP_RD;
   endfunction

endpackage

// File: rtl/dm_resp_if.sv
// MEM-stage <-> data-memory bus: request strobes, address, data and stall.
// Latency: n/a (wires only).
// Backpressure: stall from the responder holds the MEM stage.
interface dm_resp_if;
   import dm_resp_pkg::*;

   word_t addr;
   logic  re;
   logic  we;
   word_t wrt_data;
   word_t rd_data;
   logic  rd_valid;
   logic  stall;

   modport master (
      output addr, re, we, wrt_data,
      input  rd_data, rd_valid, stall
   );

   modport slave (
      input  addr, re, we, wrt_data,
      output rd_data, rd_valid, stall
   );

endinterface

// File: rtl/dm_array.sv
// Word storage: synchronous write port, combinational read port.
// Latency: write lands on the clock edge, read is same-cycle.
// Backpressure: none; always accepts.
module dm_array
   import dm_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  word_t                 wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output word_t                 rdata
);

   // Contents are intentionally not reset.
   word_t mem_q [2**DEPTH_LOG2];

   // Commit a write on the rising edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder below the MEM stage.
// Latency: stall high for LATENCY cycles per access, then one DONE cycle (rd_valid for reads).
// Backpressure: stall holds the pipeline from the request cycle until the access completes.
module dm_resp
   import dm_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2    // legal range 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   dm_resp_if.slave   bus
);

   // BUSY runs cnt down to zero; LATENCY=1 skips BUSY entirely.
   localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   dm_state_e             state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   word_t                 data_q, data_d;
   dm_op_e                op_q, op_d;
   word_t                 rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  req;
   logic                  stall;
   logic                  enter_done;
   logic [DEPTH_LOG2-1:0] req_addr;
   word_t                 req_data;
   dm_op_e                req_op;
   logic                  arr_we;
   word_t                 arr_rdata;

   assign req = bus.re | bus.we;

   // In IDLE the request is taken straight from the bus so a LATENCY=1
   // access can commit on the very edge that latches it.
   assign req_addr = (state_q == DM_IDLE) ? bus.addr[DEPTH_LOG2-1:0] : addr_q;
   assign req_data = (state_q == DM_IDLE) ? bus.wrt_data : data_q;
   assign req_op   = (state_q == DM_IDLE) ? dm_decode_op(bus.we) : op_q;

   // Upper address bits are don't-care; they alias onto the decoded range.
   generate
      if (DEPTH_LOG2 < WORD_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^bus.addr[WORD_W-1:DEPTH_LOG2];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: IDLE accepts, BUSY counts down, DONE always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DM_IDLE: begin
            if (req) begin
               state_d = (LATENCY == 1) ? DM_DONE : DM_BUSY;
            end
         end
         DM_BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = DM_DONE;
            end
         end
         DM_DONE: state_d = DM_IDLE;
         default: state_d = DM_IDLE;
      endcase
   end

   // Outputs: stall is combinational from the strobes while idle.
   always_comb begin
      stall = 1'b0;
      case (state_q)
         DM_IDLE: stall = req;
         DM_BUSY: stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   // The access takes effect on the edge that enters DONE.
   assign enter_done = (state_d == DM_DONE);

   // Gating with rst_n keeps a write from slipping in while reset is held.
   assign arr_we = enter_done && (req_op == DM_OP_WR) && rst_n;

   // Request latches and down-counter.
   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      data_d = data_q;
      op_d   = op_q;
      case (state_q)
         DM_IDLE: begin
            if (req) begin
               addr_d = bus.addr[DEPTH_LOG2-1:0];
               data_d = bus.wrt_data;
               op_d   = dm_decode_op(bus.we);
               cnt_d  = CNT_INIT;
            end
         end
         DM_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Read response: capture on entry to DONE, pulse valid for one cycle,
   // otherwise hold the last returned word.
   always_comb begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      if (enter_done && (req_op == DM_OP_RD)) begin
         rd_valid_d = 1'b1;
         rd_data_d  = arr_rdata;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         data_q     <= '0;
         op_q       <= DM_OP_RD;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         op_q       <= op_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   dm_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (req_addr),
      .wdata (req_data),
      .raddr (req_addr),
      .rdata (arr_rdata)
   );

   assign bus.stall    = stall;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: two instances (LATENCY=2 and LATENCY=1) driven by
// directed and random accesses, checked against a word-array memory model
// and the rule "stall high LATENCY cycles, then one DONE cycle".
module tb_dm_resp;

   logic clk;
   logic rst_n;

   logic        re_d   [2];
   logic        we_d   [2];
   logic [15:0] addr_d [2];
   logic [15:0] wd_d   [2];
   logic        stall_o [2];
   logic        rdv_o   [2];
   logic [15:0] rdd_o   [2];

   dm_resp_if bus0 ();
   dm_resp_if bus1 ();

   assign bus0.re       = re_d[0];
   assign bus0.we       = we_d[0];
   assign bus0.addr     = addr_d[0];
   assign bus0.wrt_data = wd_d[0];
   assign bus1.re       = re_d[1];
   assign bus1.we       = we_d[1];
   assign bus1.addr     = addr_d[1];
   assign bus1.wrt_data = wd_d[1];

   assign stall_o[0] = bus0.stall;
   assign rdv_o[0]   = bus0.rd_valid;
   assign rdd_o[0]   = bus0.rd_data;
   assign stall_o[1] = bus1.stall;
   assign rdv_o[1]   = bus1.rd_valid;
   assign rdd_o[1]   = bus1.rd_data;

   dm_resp #(.DEPTH_LOG2(10), .LATENCY(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   dm_resp #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain word array per instance plus last returned word.
   logic [15:0] mm      [2][1024];
   bit          written [2][1024];
   logic [15:0] last_rd [2];
   int          lat     [2];

   int passes = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One quiet cycle: no stall, no valid, read data held.
   task automatic idle(input int i);
      @(negedge clk);
      re_d[i] = 1'b0;
      we_d[i] = 1'b0;
      #1;
      chk($sformatf("idle%0d stall", i), 16'(stall_o[i]), 16'h0);
      chk($sformatf("idle%0d rd_valid", i), 16'(rdv_o[i]), 16'h0);
      chk($sformatf("idle%0d rd_data", i), rdd_o[i], last_rd[i]);
   endtask

   // One complete access; strobes stay asserted through DONE, as MEM would.
   task automatic access(input int i, input bit r, input bit w,
                         input logic [15:0] a, input logic [15:0] d);
      int          ia;
      bit          is_rd;
      ia    = int'(a[9:0]);
      is_rd = r && !w;
      @(negedge clk);
      re_d[i]   = r;
      we_d[i]   = w;
      addr_d[i] = a;
      wd_d[i]   = d;
      #1;
      for (int k = 0; k < lat[i]; k++) begin
         chk($sformatf("acc%0d a=%h stall[%0d]", i, a, k), 16'(stall_o[i]), 16'h1);
         chk($sformatf("acc%0d a=%h rdv[%0d]", i, a, k), 16'(rdv_o[i]), 16'h0);
         @(negedge clk);
         #1;
      end
      chk($sformatf("acc%0d a=%h done stall", i, a), 16'(stall_o[i]), 16'h0);
      chk($sformatf("acc%0d a=%h done rdv", i, a), 16'(rdv_o[i]), 16'(is_rd));
      if (is_rd) begin
         last_rd[i] = mm[i][ia];
      end
      chk($sformatf("acc%0d a=%h rd_data", i, a), rdd_o[i], last_rd[i]);
      if (w) begin
         mm[i][ia]      = d;
         written[i][ia] = 1'b1;
      end
   endtask

   initial begin
      logic [9:0]  pool [8];
      logic [15:0] a;
      int          sel;

      lat[0] = 2;
      lat[1] = 1;
      for (int i = 0; i < 2; i++) begin
         re_d[i] = 1'b0;
         we_d[i] = 1'b0;
         addr_d[i] = 16'h0;
         wd_d[i] = 16'h0;
         last_rd[i] = 16'h0;
         for (int j = 0; j < 1024; j++) written[i][j] = 1'b0;
      end

      // Reset: outputs quiet during and after.
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst%0d stall", i), 16'(stall_o[i]), 16'h0);
         chk($sformatf("rst%0d rdv", i), 16'(rdv_o[i]), 16'h0);
         chk($sformatf("rst%0d rd_data", i), rdd_o[i], 16'h0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) idle(0);
      idle(1);

      // Write then read.
      access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
      idle(0);
      access(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(0);

      // re & we together: write wins, no read pulse.
      access(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
      access(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      idle(0);

      // LATENCY=1: preload, then back-to-back reads at the 2-cycle interval.
      access(1, 1'b0, 1'b1, 16'h00A5, 16'h5A5A);
      access(1, 1'b1, 1'b0, 16'h00A5, 16'h0000);
      access(1, 1'b1, 1'b0, 16'h00A5, 16'h0000);
      idle(1);

      // Address wrap.
      access(0, 1'b0, 1'b1, 16'h0403, 16'hCAFE);
      access(0, 1'b1, 1'b0, 16'h0003, 16'h0000);
      idle(0);

      // Reset in the first BUSY cycle drops the pending write.
      access(0, 1'b0, 1'b1, 16'h0030, 16'h0001);
      @(negedge clk);
      re_d[0] = 1'b0; we_d[0] = 1'b1; addr_d[0] = 16'h0030; wd_d[0] = 16'h7777;
      #1;
      chk("rstmid stall req", 16'(stall_o[0]), 16'h1);
      @(negedge clk);
      rst_n = 1'b0;
      we_d[0] = 1'b0;
      #1;
      chk("rstmid stall", 16'(stall_o[0]), 16'h0);
      chk("rstmid rdv", 16'(rdv_o[0]), 16'h0);
      chk("rstmid rd_data", rdd_o[0], 16'h0);
      last_rd[0] = 16'h0;
      last_rd[1] = 16'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(0);
      access(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
      idle(0);

      // Random traffic against the model on both latencies.
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 8; k++) begin
            pool[k] = 10'($urandom);
            access(i, 1'b0, 1'b1, {6'($urandom), pool[k]}, 16'($urandom));
         end
         for (int n = 0; n < 40; n++) begin
            a   = {6'($urandom), pool[$urandom_range(0, 7)]};
            sel = $urandom_range(0, 4);
            case (sel)
               0, 1: access(i, 1'b1, 1'b0, a, 16'($urandom));
               2:    access(i, 1'b0, 1'b1, a, 16'($urandom));
               3:    access(i, 1'b1, 1'b1, a, 16'($urandom));
               default: idle(i);
            endcase
         end
         idle(i);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
